// File: rtl/pc_sequencer_if.sv
// Fetch-address bus between the program-counter stage and the fetch stage,
// including jump/halt control and the accepted-address status outputs.
interface pc_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             ld;
    logic [WIDTH-1:0] ld_addr;
    logic             halt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] pc;
    logic             wrap;
    logic [WIDTH-1:0] issued;

    modport master (
        input  ld, ld_addr, halt, out_ready,
        output out_valid, pc, wrap, issued
    );

    modport slave (
        output ld, ld_addr, halt, out_ready,
        input  out_valid, pc, wrap, issued
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter stage: presents the current fetch address over valid/ready,
// advances by one per accepted address, supports jump loads and halt/resume.
module pc_sequencer #(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] pc_q, pc_nxt;
    logic [WIDTH-1:0] issued_q, issued_nxt;
    logic             wrap_q, wrap_nxt;
    logic             out_valid;
    logic             fire;

    // Valid comes straight from registered state, so it never sees out_ready.
    assign out_valid = (state == RUN);
    assign fire      = out_valid && bus.out_ready;

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc_q;
        issued_nxt = issued_q;
        wrap_nxt   = 1'b0;

        if (fire) begin
            issued_nxt = issued_q + WIDTH'(1);
        end

        // A jump wins over both the increment and a halt request.
        if (bus.ld) begin
            pc_nxt    = bus.ld_addr;
            state_nxt = RUN;
        end else begin
            if (fire) begin
                pc_nxt   = pc_q + WIDTH'(1);
                wrap_nxt = (pc_q == '1);
            end
            case (state)
                IDLE:    state_nxt = RUN;
                RUN:     state_nxt = bus.halt ? HALTED : RUN;
                HALTED:  state_nxt = HALTED;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc_q     <= RESET_VECTOR;
            issued_q <= '0;
            wrap_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc_q     <= pc_nxt;
            issued_q <= issued_nxt;
            wrap_q   <= wrap_nxt;
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.pc        = pc_q;
    assign bus.issued    = issued_q;
    assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a randomized
// run compared against a behavioural model of the fetch-address sequence.
module tb_pc_sequencer;

    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    pc_sequencer_if #(.WIDTH(WIDTH)) bus ();

    pc_sequencer #(
        .WIDTH        (WIDTH),
        .RESET_VECTOR (16'h0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // Behavioural model: what the fetch stage should observe.
    logic [WIDTH-1:0] m_pc;
    logic [WIDTH-1:0] m_issued;
    logic             m_wrap;
    logic             m_valid;
    bit               m_started;

    task automatic model_reset();
        m_pc      = 16'h0000;
        m_issued  = '0;
        m_wrap    = 1'b0;
        m_valid   = 1'b0;
        m_started = 1'b0;
    endtask

    // Apply one rising edge to the model using the inputs currently driven.
    task automatic cycle();
        bit accepted;
        if (!rst_n) begin
            model_reset();
        end else begin
            accepted = m_valid && bus.out_ready;
            m_wrap   = accepted && !bus.ld && (m_pc == 16'hFFFF);
            if (accepted) m_issued = m_issued + 1;
            if (bus.ld) begin
                m_pc    = bus.ld_addr;
                m_valid = 1'b1;
            end else begin
                if (accepted) m_pc = m_pc + 1;
                if (!m_started)          m_valid = 1'b1;
                else if (bus.halt && m_valid) m_valid = 1'b0;
            end
            m_started = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ld, input logic [WIDTH-1:0] addr,
                         input logic halt, input logic ready);
        bus.ld        = ld;
        bus.ld_addr   = addr;
        bus.halt      = halt;
        bus.out_ready = ready;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        model_reset();
        #2;
        checks++;
        if ({bus.out_valid, bus.wrap, bus.pc, bus.issued} !== {1'b0, 1'b0, 16'h0000, 16'h0000}) begin
            errors++;
            $display("FAIL reset_state got v=%b w=%b pc=%h iss=%h required v=0 w=0 pc=0000 iss=0000",
                     bus.out_valid, bus.wrap, bus.pc, bus.issued);
        end
        cycle();
        cycle();
    endtask

    task automatic test_sequence();
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL boot_valid got %b required 0", bus.out_valid);
        end
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++;
            if ({bus.out_valid, bus.pc, bus.issued} !== {1'b1, 16'(i), 16'(i)}) begin
                errors++;
                $display("FAIL seq_%0d got v=%b pc=%h iss=%h required v=1 pc=%h iss=%h",
                         i, bus.out_valid, bus.pc, bus.issued, 16'(i), 16'(i));
            end
        end
    endtask

    task automatic test_backpressure();
        cycle();
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if ({bus.out_valid, bus.pc, bus.issued} !== {1'b1, 16'h0005, 16'h0005}) begin
                errors++;
                $display("FAIL stall_%0d got v=%b pc=%h iss=%h required v=1 pc=0005 iss=0005",
                         i, bus.out_valid, bus.pc, bus.issued);
            end
        end
        bus.out_ready = 1'b1;
        cycle();
        checks++;
        if ({bus.pc, bus.issued} !== {16'h0006, 16'h0006}) begin
            errors++;
            $display("FAIL stall_release got pc=%h iss=%h required pc=0006 iss=0006", bus.pc, bus.issued);
        end
    endtask

    task automatic test_jump();
        drive(1'b1, 16'h0010, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 16'h1234, 1'b0, 1'b1);
        cycle();
        checks++;
        if ({bus.out_valid, bus.pc, bus.issued} !== {1'b1, 16'h1234, 16'h0007}) begin
            errors++;
            $display("FAIL jump_fire got v=%b pc=%h iss=%h required v=1 pc=1234 iss=0007",
                     bus.out_valid, bus.pc, bus.issued);
        end
        drive(1'b1, 16'h2222, 1'b0, 1'b0);
        cycle();
        checks++;
        if ({bus.pc, bus.issued} !== {16'h2222, 16'h0007}) begin
            errors++;
            $display("FAIL jump_stall got pc=%h iss=%h required pc=2222 iss=0007", bus.pc, bus.issued);
        end
    endtask

    task automatic test_wrap();
        drive(1'b1, 16'hFFFF, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        cycle();
        checks++;
        if ({bus.wrap, bus.pc, bus.issued} !== {1'b1, 16'h0000, 16'h0008}) begin
            errors++;
            $display("FAIL wrap_set got w=%b pc=%h iss=%h required w=1 pc=0000 iss=0008",
                     bus.wrap, bus.pc, bus.issued);
        end
        bus.out_ready = 1'b0;
        cycle();
        checks++;
        if ({bus.wrap, bus.pc} !== {1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL wrap_pulse got w=%b pc=%h required w=0 pc=0000", bus.wrap, bus.pc);
        end
        drive(1'b1, 16'hFFFF, 1'b0, 1'b0);
        cycle();
        // Fire at all-ones together with a jump to zero: no wrap.
        drive(1'b1, 16'h0000, 1'b0, 1'b1);
        cycle();
        checks++;
        if ({bus.wrap, bus.pc, bus.issued} !== {1'b0, 16'h0000, 16'h0009}) begin
            errors++;
            $display("FAIL wrap_ld_zero got w=%b pc=%h iss=%h required w=0 pc=0000 iss=0009",
                     bus.wrap, bus.pc, bus.issued);
        end
    endtask

    task automatic test_halt();
        drive(1'b1, 16'h0007, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        cycle();
        checks++;
        if ({bus.out_valid, bus.pc, bus.issued} !== {1'b0, 16'h0007, 16'h0009}) begin
            errors++;
            $display("FAIL halt_enter got v=%b pc=%h iss=%h required v=0 pc=0007 iss=0009",
                     bus.out_valid, bus.pc, bus.issued);
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        cycle();
        cycle();
        checks++;
        if ({bus.out_valid, bus.pc, bus.issued} !== {1'b0, 16'h0007, 16'h0009}) begin
            errors++;
            $display("FAIL halt_hold got v=%b pc=%h iss=%h required v=0 pc=0007 iss=0009",
                     bus.out_valid, bus.pc, bus.issued);
        end
        drive(1'b1, 16'h0040, 1'b0, 1'b0);
        cycle();
        checks++;
        if ({bus.out_valid, bus.pc} !== {1'b1, 16'h0040}) begin
            errors++;
            $display("FAIL halt_resume got v=%b pc=%h required v=1 pc=0040", bus.out_valid, bus.pc);
        end
        drive(1'b1, 16'h0050, 1'b1, 1'b1);
        cycle();
        checks++;
        if ({bus.out_valid, bus.pc, bus.issued} !== {1'b1, 16'h0050, 16'h000A}) begin
            errors++;
            $display("FAIL halt_ld_override got v=%b pc=%h iss=%h required v=1 pc=0050 iss=000a",
                     bus.out_valid, bus.pc, bus.issued);
        end
        drive(1'b0, 16'h0000, 1'b1, 1'b1);
        cycle();
        checks++;
        if ({bus.out_valid, bus.pc, bus.issued} !== {1'b0, 16'h0051, 16'h000B}) begin
            errors++;
            $display("FAIL halt_with_fire got v=%b pc=%h iss=%h required v=0 pc=0051 iss=000b",
                     bus.out_valid, bus.pc, bus.issued);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 16'h00A0, 1'b0, 1'b0);
        cycle();
        bus.ld = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.wrap, bus.pc, bus.issued} !== {1'b0, 1'b0, 16'h0000, 16'h0000}) begin
            errors++;
            $display("FAIL async_reset got v=%b w=%b pc=%h iss=%h required v=0 w=0 pc=0000 iss=0000",
                     bus.out_valid, bus.wrap, bus.pc, bus.issued);
        end
        model_reset();
        cycle();
        bus.out_ready = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if ({bus.out_valid, bus.pc, bus.issued} !== {1'b1, 16'(i), 16'(i)}) begin
                errors++;
                $display("FAIL restart_%0d got v=%b pc=%h iss=%h required v=1 pc=%h iss=%h",
                         i, bus.out_valid, bus.pc, bus.issued, 16'(i), 16'(i));
            end
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] addr;
        for (int i = 0; i < 400; i++) begin
            addr = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 2))
                                               : 16'($urandom);
            drive($urandom_range(0, 9) == 0, addr, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 1) == 1);
            cycle();
            checks++;
            if ({bus.out_valid, bus.wrap, bus.pc, bus.issued} !== {m_valid, m_wrap, m_pc, m_issued}) begin
                errors++;
                $display("FAIL rand_%0d got v=%b w=%b pc=%h iss=%h required v=%b w=%b pc=%h iss=%h",
                         i, bus.out_valid, bus.wrap, bus.pc, bus.issued,
                         m_valid, m_wrap, m_pc, m_issued);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_backpressure();
        test_jump();
        test_wrap();
        test_halt();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
